// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame layout and scan codes
// also used by the downstream scan-code-to-ASCII controller.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   localparam logic [7:0] BREAK  = 8'hF0;
   localparam logic [7:0] LSHIFT = 8'h12;

   // Odd parity holds when the data bits plus the parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_input_sync.sv
// Synchronises the raw PS/2 pins, de-glitches ps2clk and emits a one-cycle
// pulse on each accepted falling edge together with the synchronised data bit.
module ps2_input_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2clk_raw,
   input  logic ps2data_raw,
   output logic fall,
   output logic data
);

   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic [CW-1:0]          filt_cnt_q, filt_cnt_d;
   logic                   filt_q, filt_d;
   logic                   fall_q, fall_d;
   logic                   clk_sample;

   assign clk_sample = clk_sync_q[SYNC_STAGES-1];

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2clk_raw};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2data_raw};
      filt_d      = filt_q;
      filt_cnt_d  = '0;
      fall_d      = 1'b0;
      // The counter tracks how long the sample has disagreed with the filtered level;
      // any agreeing sample restarts it, so short glitches never flip the level.
      if (clk_sample != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = clk_sample;
            fall_d = ~clk_sample;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         filt_cnt_q  <= '0;
         filt_q      <= 1'b1;
         fall_q      <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         filt_cnt_q  <= filt_cnt_d;
         filt_q      <= filt_d;
         fall_q      <= fall_d;
      end
   end

   assign fall = fall_q;
   assign data = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Define PS2_PARITY_CHECK_EN to enforce parity and expose the frame_err strobe.
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Hclock,
   input  logic       Hreset,
   input  logic       ps2clk,
   input  logic       ps2data,
   output logic [7:0] receiveData,
   output logic       Hready
`ifdef PS2_PARITY_CHECK_EN
   ,
   output logic       frame_err
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam logic CHECK_PARITY = 1'b1;
`else
   localparam logic CHECK_PARITY = 1'b0;
`endif

   logic fall, data;

   ps2_input_sync #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_sync (
      .clk         (Hclock),
      .rst_n       (Hreset),
      .ps2clk_raw  (ps2clk),
      .ps2data_raw (ps2data),
      .fall        (fall),
      .data        (data)
   );

   ps2_state_t     state_q, state_d;
   logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           parity_q, parity_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [7:0]     rx_data_q, rx_data_d;
   logic           ready_q, ready_d;
   logic           frame_good;
`ifdef PS2_PARITY_CHECK_EN
   logic           err_q, err_d;
`endif

   assign frame_good = (data == STOP_BIT) &&
                       (odd_parity_ok(shift_q, parity_q) || !CHECK_PARITY);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      tmo_d     = tmo_q;
      rx_data_d = rx_data_q;
      ready_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      err_d     = 1'b0;
`endif

      // A fall pulse always clears the counter, so timeout and fall never coincide.
      if (state_q == IDLE || fall) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         tmo_d   = '0;
         state_d = IDLE;
`ifdef PS2_PARITY_CHECK_EN
         err_d   = 1'b1;
`endif
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      if (fall) begin
         case (state_q)
            IDLE: begin
               if (data == START_BIT) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d[bit_cnt_q] = data;
               bit_cnt_d          = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) state_d = PARITY;
            end
            PARITY: begin
               parity_d = data;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (frame_good) begin
                  rx_data_d = shift_q;
                  ready_d   = 1'b1;
               end else begin
`ifdef PS2_PARITY_CHECK_EN
                  err_d = 1'b1;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Hclock or negedge Hreset) begin
      if (!Hreset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         tmo_q     <= '0;
         rx_data_q <= 8'h00;
         ready_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         tmo_q     <= tmo_d;
         rx_data_q <= rx_data_d;
         ready_q   <= ready_d;
`ifdef PS2_PARITY_CHECK_EN
         err_q     <= err_d;
`endif
      end
   end

   assign receiveData = rx_data_q;
   assign Hready      = ready_q;
`ifdef PS2_PARITY_CHECK_EN
   assign frame_err   = err_q;
`endif

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: a table of whole frames plus hand-written
// timeout, glitch and mid-frame reset sequences.
module tb_ps2_frame_receiver;
   import ps2_pkg::*;

   localparam int H   = 40;     // ps2clk half period in Hclock cycles
   localparam int TMO = 1000;
   localparam int LAT = 11;     // drive of stop fall -> Hready seen: 2 sync + 8 filter + 1 FSM

   logic       Hclock = 1'b0;
   logic       Hreset = 1'b0;
   logic       ps2clk = 1'b1;
   logic       ps2data = 1'b1;
   logic [7:0] receiveData;
   logic       Hready;
`ifdef PS2_PARITY_CHECK_EN
   logic       frame_err;
`endif

   ps2_frame_receiver #(
      .SYNC_STAGES    (2),
      .FILTER_CYCLES  (8),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .Hclock      (Hclock),
      .Hreset      (Hreset),
      .ps2clk      (ps2clk),
      .ps2data     (ps2data),
      .receiveData (receiveData),
      .Hready      (Hready)
`ifdef PS2_PARITY_CHECK_EN
      ,
      .frame_err   (frame_err)
`endif
   );

   always #5 Hclock = ~Hclock;

   int cyc = 0;
   always @(posedge Hclock) cyc++;

   int         tests = 0;
   int         fails = 0;
   int         ready_cnt = 0;
   int         ready_cyc = 0;
   logic [7:0] ready_data = 8'h00;
   int         err_cnt = 0;

   always @(negedge Hclock) begin
      if (Hready) begin
         ready_cnt++;
         ready_cyc  = cyc;
         ready_data = receiveData;
      end
`ifdef PS2_PARITY_CHECK_EN
      if (frame_err) err_cnt++;
`endif
   end

   typedef struct {
      string      name;
      logic [7:0] d;
      bit         bad_par;
      bit         bad_stop;
      bit         glitch;
      int         exp_ready;
      logic [7:0] exp_data;
      int         exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Hclock);
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic par;
      par = (~^d) ^ bad_par;
      return {~bad_stop, par, d, START_BIT};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch,
                            output int stop_cyc);
      stop_cyc = 0;
      for (int i = 0; i < nbits; i++) begin
         ps2data = bits[i];
         tick(H);
         ps2clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         tick(H);
         ps2clk = 1'b1;
         if (glitch && i < 10) begin
            tick(15);
            ps2clk = 1'b0;
            tick(3);
            ps2clk = 1'b1;
         end
      end
      ps2data = 1'b1;
   endtask

   task automatic run_frame(input vec_t v);
      int r0, e0, stop_cyc;
      r0 = ready_cnt;
      e0 = err_cnt;
      send_bits(make_frame(v.d, v.bad_par, v.bad_stop), 11, v.glitch, stop_cyc);
      tick(3 * H);
      check({v.name, " ready_pulses"}, ready_cnt - r0, v.exp_ready);
      if (v.exp_ready == 1) begin
         check({v.name, " latency"}, ready_cyc - stop_cyc, LAT);
         check({v.name, " strobe_data"}, ready_data, v.exp_data);
      end
      check({v.name, " receiveData"}, receiveData, v.exp_data);
`ifdef PS2_PARITY_CHECK_EN
      check({v.name, " frame_err"}, err_cnt - e0, v.exp_err);
`endif
      $display("[TB] frame %s data=%02h ready=%0d receiveData=%02h", v.name, v.d,
               ready_cnt - r0, receiveData);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, e0, dummy;
      vec_t v;

      vecs[0] = '{"good_1C",    8'h1C, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 0};
      vecs[1] = '{"good_F0",    BREAK, 1'b0, 1'b0, 1'b0, 1, 8'hF0, 0};
      vecs[2] = '{"good_1C_b",  8'h1C, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 0};
`ifdef PS2_PARITY_CHECK_EN
      vecs[3] = '{"badpar_12",  LSHIFT, 1'b1, 1'b0, 1'b0, 0, 8'h1C, 1};
      vecs[4] = '{"badstop_1C", 8'h1C, 1'b0, 1'b1, 1'b0, 0, 8'h1C, 1};
`else
      vecs[3] = '{"badpar_12",  LSHIFT, 1'b1, 1'b0, 1'b0, 1, 8'h12, 0};
      vecs[4] = '{"badstop_1C", 8'h1C, 1'b0, 1'b1, 1'b0, 0, 8'h12, 1};
`endif
      vecs[5] = '{"good_12",    LSHIFT, 1'b0, 1'b0, 1'b0, 1, 8'h12, 0};

      tick(3);
      check("reset receiveData", receiveData, 8'h00);
      check("reset Hready", Hready, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      check("reset frame_err", frame_err, 1'b0);
`endif
      Hreset = 1'b1;
      tick(5);

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);

      // Partial frame abandoned: only the timeout can bring the receiver back to IDLE.
      r0 = ready_cnt;
      e0 = err_cnt;
      send_bits(make_frame(8'h1C, 1'b0, 1'b0), 5, 1'b0, dummy);
      tick(TMO + 10);
      check("timeout no_ready", ready_cnt - r0, 0);
      check("timeout data_held", receiveData, 8'h12);
`ifdef PS2_PARITY_CHECK_EN
      check("timeout frame_err", err_cnt - e0, 1);
`endif
      $display("[TB] timeout sequence ready=%0d err=%0d", ready_cnt - r0, err_cnt - e0);
      v = '{"after_tmo_1C", 8'h1C, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 0};
      run_frame(v);

      v = '{"after_tmo_12", LSHIFT, 1'b0, 1'b0, 1'b0, 1, 8'h12, 0};
      run_frame(v);
      v = '{"glitch_1C", 8'h1C, 1'b0, 1'b0, 1'b1, 1, 8'h1C, 0};
      run_frame(v);

      // Reset in the middle of a frame, then a clean frame.
      send_bits(make_frame(LSHIFT, 1'b0, 1'b0), 4, 1'b0, dummy);
      tick(5);
      Hreset = 1'b0;
      tick(2);
      check("midreset receiveData", receiveData, 8'h00);
      check("midreset Hready", Hready, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      check("midreset frame_err", frame_err, 1'b0);
`endif
      $display("[TB] mid-frame reset receiveData=%02h", receiveData);
      Hreset = 1'b1;
      tick(H);
      v = '{"post_reset_12", LSHIFT, 1'b0, 1'b0, 1'b0, 1, 8'h12, 0};
      run_frame(v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
